ps2_input_mapper: RTL and testbench
===================================

// Module: ps2_input_mapper
// PURPOSE
//  Parametrised keyboard+joystick input front end for arcade cores. Decodes hps_io
//  ps2_key toggle events against a table of up to NUM_BTN scan codes and holds
//  per-button key state. ORs in joystick bits and stretches the coin output.
//  Sits between hps_io and the game core, replacing hand-written casex decoders.
// PARAMETERS
//  NUM_BTN    16         number of logical buttons (1..32)
//  KEYMAP     {NUM_BTN{10'h0}}  entry i = bits [10*i+9:10*i] = {ext_dc, ext, code[7:0]}
//  COIN_IDX   0          button index whose output is pulse-stretched
//  COIN_MIN   16'd0      minimum coin high time in clk_sys cycles; 0 = no stretch
//  SOCD_PAIRS 0          pairs (2k,2k+1), k<SOCD_PAIRS, resolved when INPUT_SOCD_EN set
// PORTS
//  clk_sys     in   1        system clock; all logic on posedge
//  reset_n     in   1        synchronous reset, active low
//  ps2_key     in   11       [10] toggle, [9] pressed, [8] extended, [7:0] code
//  joy_in      in   NUM_BTN  joystick bits already in button order, active high
//  release_all in   1        clears all key state (OSD open, focus loss)
//  btn_out     out  NUM_BTN  registered merged button state, active high
//  key_event   out  1        one-cycle strobe per accepted toggle (any code)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): key_state=0, btn_out=0, key_event=0, coin_cnt=0,
//    old_tog<=ps2_key[10] so no spurious event on release of reset.
//  - Event: ps2_key[10]!=old_tog at a posedge; old_tog updated every cycle.
//  - Match entry i: code==KEYMAP.code && (ext_dc || ps2_key[8]==KEYMAP.ext).
//    Every matching entry gets key_state[i]<=ps2_key[9]; duplicates legal.
//    Unmatched codes change nothing. key_event=1 the cycle after any event.
//  - Latency: key_state updates edge N+1 after toggle seen at edge N; btn_out at N+2.
//    joy_in -> btn_out: 1 cycle. btn_out = key_state | joy_in (pre-SOCD, pre-stretch).
//  - release_all: key_state<=0 next edge; wins over a simultaneous event (event
//    still strobes key_event, old_tog still updates). joy_in unaffected.
//  - Coin stretch (COIN_MIN>0): raw rising edge on merged[COIN_IDX] loads
//    coin_cnt=COIN_MIN-1; btn_out[COIN_IDX] stays 1 while coin_cnt!=0 or raw=1;
//    coin_cnt decrements to 0, saturates. Re-press during count reloads.
//    COIN_MIN=0: btn_out[COIN_IDX] = raw, counter optimised away.
//  - Consecutive toggles on back-to-back cycles each processed; no queue, no loss.
//  - Reset mid-stretch aborts stretch; btn_out 0 next cycle.
// CONFIGURATION
//  INPUT_SOCD_EN defined: for each pair k<SOCD_PAIRS, if merged[2k] and merged[2k+1]
//    both 1, both outputs forced 0 (neutral); applied before coin stretch,
//    same latency. Pairs must not include COIN_IDX.
//  INPUT_SOCD_EN undefined: pairs pass through unchanged; SOCD_PAIRS ignored.
// TESTING
//  1 KEYMAP[0]={1,0,8'h75}: toggle with {pressed=1,ext=1,75} -> btn_out[0]=1 two edges later;
//    toggle {pressed=0,ext=0,75} -> btn_out[0]=0 (ext don't-care).
//  2 KEYMAP[1]={0,1,8'h6B}: press with ext=0 -> no change, key_event=1; ext=1 -> btn_out[1]=1.
//  3 COIN_MIN=16: one-cycle joy_in[COIN_IDX] pulse -> btn_out[COIN_IDX] high exactly 16 cycles.
//  4 Hold key 1, assert release_all same cycle as new press toggle -> all btn_out 0, key_event=1.
//  5 INPUT_SOCD_EN, SOCD_PAIRS=1: joy_in[0]=joy_in[1]=1 -> btn_out[1:0]=00; undefined -> 11.
//  6 Reset asserted with ps2_key[10]=1 then released -> no key_event, btn_out=0 until real toggle.

Source files
------------

// File: rtl/ps2_input_mapper.sv
// Keyboard + joystick front end: decodes ps2_key toggle events against KEYMAP,
// merges joystick bits and stretches the coin button. Optional SOCD: INPUT_SOCD_EN.
module ps2_input_mapper #(
  parameter int                    NUM_BTN    = 16,
  parameter logic [10*NUM_BTN-1:0] KEYMAP     = '0,
  parameter int                    COIN_IDX   = 0,
  parameter logic [15:0]           COIN_MIN   = 16'd0,
  parameter int                    SOCD_PAIRS = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        ps2_key,
  input  logic [NUM_BTN-1:0] joy_in,
  input  logic               release_all,
  output logic [NUM_BTN-1:0] btn_out,
  output logic               key_event
);

  logic               old_tog;
  logic               evt;
  logic               pend_v;
  logic [9:0]         pend_key;
  logic [NUM_BTN-1:0] key_state;
  logic [NUM_BTN-1:0] hit;
  logic [NUM_BTN-1:0] merged;
  logic [NUM_BTN-1:0] resolved;
  logic [NUM_BTN-1:0] stretched;
  logic               raw;

  assign evt = ps2_key[10] ^ old_tog;

  // Entry layout {ext_dc, ext, code}; ext_dc entries match either code page.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hit[i] = pend_v
             && (pend_key[7:0] == KEYMAP[10*i +: 8])
             && (KEYMAP[10*i+9] || (pend_key[8] == KEYMAP[10*i+8]));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      old_tog   <= ps2_key[10];
      pend_v    <= 1'b0;
      pend_key  <= '0;
      key_event <= 1'b0;
      key_state <= '0;
    end else begin
      old_tog   <= ps2_key[10];
      key_event <= evt;
      pend_v    <= evt & ~release_all;
      pend_key  <= ps2_key[9:0];
      if (release_all) begin
        key_state <= '0;
      end else begin
        for (int i = 0; i < NUM_BTN; i++) begin
          if (hit[i]) key_state[i] <= pend_key[9];
        end
      end
    end
  end

  assign merged = key_state | joy_in;

`ifdef INPUT_SOCD_EN
  localparam int NPAIRS = (SOCD_PAIRS > NUM_BTN / 2) ? NUM_BTN / 2 : SOCD_PAIRS;

  // Opposing directions held together resolve to neutral.
  always_comb begin
    resolved = merged;
    for (int k = 0; k < NPAIRS; k++) begin
      if (merged[2*k] && merged[2*k+1]) begin
        resolved[2*k]   = 1'b0;
        resolved[2*k+1] = 1'b0;
      end
    end
  end
`else
  assign resolved = merged;
`endif

  assign raw = resolved[COIN_IDX];

  generate
    if (COIN_MIN != 16'd0) begin : g_coin
      logic [15:0] coin_cnt;
      logic        raw_q;

      always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
          coin_cnt <= '0;
          raw_q    <= 1'b0;
        end else begin
          raw_q <= raw;
          if (raw && !raw_q)
            coin_cnt <= COIN_MIN - 16'd1;
          else if (coin_cnt != 16'd0)
            coin_cnt <= coin_cnt - 16'd1;
        end
      end

      always_comb begin
        stretched           = resolved;
        stretched[COIN_IDX] = raw | (coin_cnt != 16'd0);
      end
    end else begin : g_no_coin
      assign stretched = resolved;
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (!reset_n) btn_out <= '0;
    else          btn_out <= stretched;
  end

endmodule

// File: tb/tb_ps2_input_mapper.sv
// Directed bench for ps2_input_mapper with a cycle-level reference model
// built from event timestamps and a pending-update list.
module tb_ps2_input_mapper;

  localparam int          N    = 4;
  localparam int          COIN = 3;
  localparam logic [15:0] CMIN = 16'd16;
  localparam logic [10*N-1:0] KM = {10'h021, 10'h01C, {1'b0, 1'b1, 8'h6B}, {1'b1, 1'b0, 8'h75}};

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic [10:0]  ps2_key;
  logic [N-1:0] joy_in;
  logic         release_all;
  logic [N-1:0] btn_out;
  logic         key_event;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_input_mapper #(
    .NUM_BTN(N), .KEYMAP(KM), .COIN_IDX(COIN), .COIN_MIN(CMIN), .SOCD_PAIRS(1)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
    .release_all(release_all), .btn_out(btn_out), .key_event(key_event)
  );

  // Reference model: key updates land one edge after the event, outputs one edge later;
  // the coin output is held until a timestamp set on each rising edge of the raw value.
  logic [N-1:0] m_keys, exp_btn, m_mer;
  logic         exp_evt, m_old, m_pv, m_prev_raw, m_raw;
  logic         m_valid = 1'b0;
  logic [9:0]   m_pk;
  longint       cyc = 0, stretch_end = 0;

  function automatic logic key_matches(int i, logic [9:0] k);
    logic [9:0] e;
    e = KM[10*i +: 10];
    return (k[7:0] == e[7:0]) && (e[9] || (k[8] == e[8]));
  endfunction

  always @(posedge clk_sys) begin
    cyc++;
    if (!reset_n) begin
      m_keys = '0; exp_btn = '0; exp_evt = 1'b0; m_old = ps2_key[10];
      m_pv = 1'b0; stretch_end = 0; m_prev_raw = 1'b0; m_valid = 1'b1;
    end else begin
      m_mer = m_keys | joy_in;
`ifdef INPUT_SOCD_EN
      if (m_mer[0] && m_mer[1]) m_mer[1:0] = 2'b00;
`endif
      m_raw = m_mer[COIN];
      if (m_raw && !m_prev_raw) stretch_end = cyc + longint'(CMIN);
      m_prev_raw = m_raw;
      exp_btn = m_mer;
      exp_btn[COIN] = m_raw || (cyc < stretch_end);
      if (release_all) m_keys = '0;
      else if (m_pv)
        for (int i = 0; i < N; i++) if (key_matches(i, m_pk)) m_keys[i] = m_pk[9];
      exp_evt = (ps2_key[10] != m_old);
      m_old   = ps2_key[10];
      m_pv    = exp_evt && !release_all;
      m_pk    = ps2_key[9:0];
    end
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      checks++;
      if (btn_out !== exp_btn) begin
        failures++;
        $display("FAIL model_btn_out t=%0t actual=%b expected=%b", $time, btn_out, exp_btn);
      end
      checks++;
      if (key_event !== exp_evt) begin
        failures++;
        $display("FAIL model_key_event t=%0t actual=%b expected=%b", $time, key_event, exp_evt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
    @(negedge clk_sys);
  endtask

  int coin_high;

  initial begin
    reset_n = 1'b0; ps2_key = '0; joy_in = '0; release_all = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset_btn", 32'(btn_out), 32'h0);
    chk("reset_evt", 32'(key_event), 32'h0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // ext don't-care entry
    send(1'b1, 1'b1, 8'h75);
    chk("t1_evt", 32'(key_event), 32'h1);
    @(negedge clk_sys);
    chk("t1_btn0_early", 32'(btn_out[0]), 32'h0);
    chk("t1_evt_once", 32'(key_event), 32'h0);
    @(negedge clk_sys);
    chk("t1_btn0_on", 32'(btn_out[0]), 32'h1);
    send(1'b0, 1'b0, 8'h75);
    repeat (2) @(negedge clk_sys);
    chk("t1_btn0_off", 32'(btn_out[0]), 32'h0);

    // ext must match
    send(1'b1, 1'b0, 8'h6B);
    chk("t2_evt_nomatch", 32'(key_event), 32'h1);
    repeat (2) @(negedge clk_sys);
    chk("t2_btn1_nomatch", 32'(btn_out[1]), 32'h0);
    send(1'b1, 1'b1, 8'h6B);
    repeat (2) @(negedge clk_sys);
    chk("t2_btn1_on", 32'(btn_out[1]), 32'h1);

    // back-to-back toggles
    send(1'b1, 1'b1, 8'h75);
    send(1'b1, 1'b0, 8'h1C);
    chk("b2b_evt2", 32'(key_event), 32'h1);
    repeat (2) @(negedge clk_sys);
    chk("b2b_btn", 32'(btn_out), 32'h7);

    // release_all beats a simultaneous press (coin key)
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h21};
    release_all = 1'b1;
    @(negedge clk_sys);
    release_all = 1'b0;
    chk("t4_evt", 32'(key_event), 32'h1);
    repeat (2) @(negedge clk_sys);
    chk("t4_btn_clear", 32'(btn_out), 32'h0);

    // coin stretch from a single-cycle pulse
    joy_in[COIN] = 1'b1;
    @(negedge clk_sys);
    joy_in = '0;
    coin_high = 0;
    for (int i = 0; i < 40; i++) begin
      if (btn_out[COIN]) coin_high++;
      @(negedge clk_sys);
    end
    chk("t3_coin_len", 32'(coin_high), 32'd16);

    // SOCD pair 0
    joy_in = 4'b0011;
    repeat (2) @(negedge clk_sys);
`ifdef INPUT_SOCD_EN
    chk("t5_socd", 32'(btn_out[1:0]), 32'h0);
`else
    chk("t5_socd", 32'(btn_out[1:0]), 32'h3);
`endif
    joy_in = '0;
    repeat (2) @(negedge clk_sys);

    // reset mid-stretch with toggle flipped during reset
    joy_in[COIN] = 1'b1;
    @(negedge clk_sys);
    joy_in = '0;
    repeat (4) @(negedge clk_sys);
    chk("t6_stretching", 32'(btn_out[COIN]), 32'h1);
    reset_n = 1'b0;
    ps2_key[10] = ~ps2_key[10];
    @(negedge clk_sys);
    chk("t6_abort", 32'(btn_out), 32'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      chk("t6_no_evt", 32'(key_event), 32'h0);
      chk("t6_btn_zero", 32'(btn_out), 32'h0);
    end
    send(1'b1, 1'b1, 8'h75);
    chk("t6_real_evt", 32'(key_event), 32'h1);
    repeat (2) @(negedge clk_sys);
    chk("t6_btn0", 32'(btn_out[0]), 32'h1);
    repeat (2) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
